// File: rtl/stream_fifo_pkg.sv
// stream_fifo_pkg: shared pointer sizing and parameter legality helpers for stream_fifo
package stream_fifo_pkg;
  function automatic int ptr_width(int depth);
    return $clog2(depth) + 1;
  endfunction
  function automatic bit params_ok(int width, int depth, int af, int ae);
    return width >= 1 && depth >= 2 && (depth & (depth - 1)) == 0 &&
           af >= 1 && af <= depth && ae >= 0 && ae < depth;
  endfunction
endpackage

// File: rtl/stream_fifo_ram.sv
// stream_fifo_ram: unreset storage with one synchronous write port and one combinational read port
module stream_fifo_ram #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  parameter int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);
  logic [WIDTH-1:0] mem [DEPTH];
  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;
  assign rdata = mem[raddr];
endmodule

// File: rtl/stream_fifo.sv
// stream_fifo: valid/ready FIFO with registered first-word-fall-through head, occupancy count and level flags
module stream_fifo
  import stream_fifo_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  parameter int AF_LEVEL = DEPTH - 2,
  parameter int AE_LEVEL = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   flush,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [WIDTH-1:0]       in_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [WIDTH-1:0]       out_data,
  output logic [$clog2(DEPTH):0] count,
  output logic                   almost_full,
  output logic                   almost_empty
);
  localparam int PW = ptr_width(DEPTH);
  localparam int AW = PW - 1;
  if (!params_ok(WIDTH, DEPTH, AF_LEVEL, AE_LEVEL)) begin : g_bad_params
    $error("stream_fifo: illegal WIDTH/DEPTH/AF_LEVEL/AE_LEVEL");
  end
  logic [PW-1:0] wr_ptr, rd_ptr, count_next;
  logic [WIDTH-1:0] ram_rdata;
  logic clr, push, pop, ram_empty, load, ram_we;
  // The RAM holds only words behind the head register, so it never needs more than DEPTH-1 slots
  always_comb begin
    clr = !rst_n | flush;
    push = in_valid & in_ready & !clr;
    pop = out_valid & out_ready & !clr;
    ram_empty = wr_ptr == rd_ptr;
    load = !out_valid | pop;
    ram_we = push & !(load & ram_empty);
    count_next = clr ? '0 : count + PW'(push) - PW'(pop);
  end
  stream_fifo_ram #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW)) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .waddr (wr_ptr[AW-1:0]),
    .wdata (in_data),
    .raddr (rd_ptr[AW-1:0]),
    .rdata (ram_rdata)
  );
  always_ff @(posedge clk) begin
    count <= count_next;
    in_ready <= count_next < PW'(DEPTH);
    almost_full <= count_next >= PW'(AF_LEVEL);
    almost_empty <= count_next <= PW'(AE_LEVEL);
    if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      out_valid <= 1'b0;
    end else begin
      if (ram_we) wr_ptr <= wr_ptr + PW'(1);
      if (load) out_valid <= !ram_empty | push;
      if (load && !ram_empty) rd_ptr <= rd_ptr + PW'(1);
    end
    if (!rst_n) out_data <= '0;
    else if (!flush && load && (!ram_empty || push)) out_data <= ram_empty ? in_data : ram_rdata;
  end
endmodule
